// File: rtl/fan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fan_ctrl_pkg
//  Description : Shared types and helpers for the multi-channel fan controller:
//                sweep FSM state encoding, signed saturation and duty clamps.
//  Revision    : 1.0 - initial release
// ============================================================================
package fan_ctrl_pkg;

    // Controller sweep sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    // Clamp a signed value into the range of a signed field 'width' bits wide
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

    // Automatic-mode duty: off for non-positive demand, else floor at pwm_min
    // so the fan never stalls, and never beyond a full period
    function automatic int duty_clamp(input int pid, input int pwm_min, input int period);
        int d;
        if (pid <= 0) begin
            d = 0;
        end else begin
            d = (pid < pwm_min) ? pwm_min : pid;
            if (d > period) begin
                d = period;
            end
        end
        return d;
    endfunction

    // Manual-mode duty: operator value limited to a full period
    function automatic int manual_duty_clamp(input int duty, input int period);
        return (duty > period) ? period : duty;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fan_pi_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : fan_pi_datapath
//  Description : Combinational PI step shared by all fan channels: error,
//                full-precision MAC, anti-windup saturation, output shift,
//                duty clamp and the bumpless manual-override path.
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_pi_datapath
    import fan_ctrl_pkg::*;
#(
    parameter int ADC_BW     = 4,
    parameter int COEF_BW    = 8,
    parameter int FRAC_BW    = 6,
    parameter int PWM_PERIOD = 18
)
(
    input  logic                              i_manual,
    input  logic        [ADC_BW:0]            i_manual_duty,
    input  logic        [ADC_BW-1:0]          i_adc,
    input  logic        [ADC_BW-1:0]          i_set,
    input  logic signed [ADC_BW:0]            i_e_prev,
    input  logic signed [ADC_BW+FRAC_BW:0]    i_acc,
    input  logic signed [COEF_BW-1:0]         i_b2,
    input  logic signed [COEF_BW-1:0]         i_b1,
    input  logic        [ADC_BW-1:0]          i_pwm_min,
    output logic signed [ADC_BW:0]            o_e,
    output logic signed [ADC_BW+FRAC_BW:0]    o_acc_nxt,
    output logic signed [ADC_BW:0]            o_pid_nxt,
    output logic        [ADC_BW:0]            o_duty_nxt
);

    localparam int c_ew = ADC_BW + 1;
    localparam int c_aw = ADC_BW + 1 + FRAC_BW;

    logic signed [31:0] w_sum;
    logic signed [31:0] w_man_acc;

    // One PI step; manual mode preloads the accumulator so release is bumpless
    always_comb begin
        o_e       = signed'({1'b0, i_adc}) - signed'({1'b0, i_set});
        w_sum     = 32'(i_acc) + 32'(i_b2) * 32'(o_e) + 32'(i_b1) * 32'(i_e_prev);
        w_man_acc = 32'(i_manual_duty) << FRAC_BW;
        if (i_manual) begin
            o_acc_nxt  = c_aw'(sat_signed(w_man_acc, c_aw));
            o_pid_nxt  = c_ew'(sat_signed(32'(i_manual_duty), c_ew));
            o_duty_nxt = c_ew'(manual_duty_clamp(int'(i_manual_duty), PWM_PERIOD));
        end else begin
            o_acc_nxt  = c_aw'(sat_signed(w_sum, c_aw));
            o_pid_nxt  = c_ew'(o_acc_nxt >>> FRAC_BW);
            o_duty_nxt = c_ew'(duty_clamp(int'(o_pid_nxt), int'(i_pwm_min), PWM_PERIOD));
        end
    end

endmodule
`default_nettype wire

// File: rtl/fan_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : fan_ctrl_multi
//  Description : Multi-channel fan controller. One time-multiplexed PI datapath
//                serves all channels in a LOAD/MAC/STORE sweep started by a
//                tick divider; one shared PWM counter drives all fan outputs
//                with duty updates applied only at the period wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module fan_ctrl_multi
    import fan_ctrl_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int ADC_BW       = 4,
    parameter int COEF_BW      = 8,
    parameter int FRAC_BW      = 6,
    parameter int PID_TICK_DIV = 200000,
    parameter int PWM_PERIOD   = 18
)
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clk_en_i,
    input  logic [CHANNELS*ADC_BW-1:0]       adc_i,
    input  logic [CHANNELS*ADC_BW-1:0]       set_i,
    input  logic [CHANNELS-1:0]              manual_i,
    input  logic [CHANNELS*(ADC_BW+1)-1:0]   manual_duty_i,
    input  logic [COEF_BW-1:0]               b2_i,
    input  logic [COEF_BW-1:0]               b1_i,
    input  logic [ADC_BW-1:0]                pwm_min_i,
    output logic [CHANNELS-1:0]              pwm_o,
    output logic [CHANNELS*(ADC_BW+1)-1:0]   pid_val_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int c_ew   = ADC_BW + 1;
    localparam int c_aw   = ADC_BW + 1 + FRAC_BW;
    localparam int c_chw  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_divw = $clog2(PID_TICK_DIV);

    localparam logic [c_divw-1:0] c_div_last = c_divw'(PID_TICK_DIV - 1);
    localparam logic [c_chw-1:0]  c_ch_last  = c_chw'(CHANNELS - 1);
    localparam logic [c_ew-1:0]   c_cnt_last = c_ew'(PWM_PERIOD - 1);

    // Parameter sanity checks at elaboration
    if (PID_TICK_DIV < 4 * CHANNELS) begin : g_chk_div
        $error("PID_TICK_DIV must be at least 4*CHANNELS");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_chk_channels
        $error("CHANNELS must be in 1..8");
    end
    if (PWM_PERIOD < 2 || PWM_PERIOD > (2 ** (ADC_BW + 1)) - 1) begin : g_chk_period
        $error("PWM_PERIOD out of range");
    end

    // Tick divider
    logic [c_divw-1:0] r_div;
    logic              w_tick;

    // Sweep sequencer and per-channel state
    fsm_state_t               r_state;
    logic [c_chw-1:0]         r_ch;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_man;
    logic [c_ew-1:0]          r_man_duty;
    logic [ADC_BW-1:0]        r_adc;
    logic [ADC_BW-1:0]        r_set;
    logic signed [c_ew-1:0]   r_e_prev_ld;
    logic signed [c_aw-1:0]   r_acc_ld;
    logic signed [c_ew-1:0]   r_e_new;
    logic signed [c_aw-1:0]   r_acc_new;
    logic signed [c_ew-1:0]   r_pid_new;
    logic [c_ew-1:0]          r_duty_new;
    logic signed [c_aw-1:0]   r_acc_mem     [CHANNELS];
    logic signed [c_ew-1:0]   r_eprev_mem   [CHANNELS];
    logic [c_ew-1:0]          r_duty_shadow [CHANNELS];
    logic [CHANNELS*c_ew-1:0] r_pid_val;

    // Datapath results
    logic signed [c_ew-1:0]   w_e;
    logic signed [c_aw-1:0]   w_acc_nxt;
    logic signed [c_ew-1:0]   w_pid_nxt;
    logic [c_ew-1:0]          w_duty_nxt;

    // PWM
    logic [c_ew-1:0]          r_cnt;
    logic [c_ew-1:0]          w_cnt_nxt;
    logic                     w_pwm_wrap;
    logic [c_ew-1:0]          r_duty_active [CHANNELS];
    logic [c_ew-1:0]          w_duty_sel    [CHANNELS];
    logic [CHANNELS-1:0]      w_pwm_nxt;
    logic [CHANNELS-1:0]      r_pwm;

    assign w_tick = clk_en_i && (r_div == c_div_last);

    // Free-running sweep-rate divider on enabled cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div <= '0;
        end else if (clk_en_i) begin
            r_div <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
        end
    end

    fan_pi_datapath #(
        .ADC_BW     (ADC_BW),
        .COEF_BW    (COEF_BW),
        .FRAC_BW    (FRAC_BW),
        .PWM_PERIOD (PWM_PERIOD)
    ) u_datapath (
        .i_manual      (r_man),
        .i_manual_duty (r_man_duty),
        .i_adc         (r_adc),
        .i_set         (r_set),
        .i_e_prev      (r_e_prev_ld),
        .i_acc         (r_acc_ld),
        .i_b2          (b2_i),
        .i_b1          (b1_i),
        .i_pwm_min     (pwm_min_i),
        .o_e           (w_e),
        .o_acc_nxt     (w_acc_nxt),
        .o_pid_nxt     (w_pid_nxt),
        .o_duty_nxt    (w_duty_nxt)
    );

    // Sweep sequencer: LOAD latches one channel, MAC captures the step, STORE commits it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_man       <= 1'b0;
            r_man_duty  <= '0;
            r_adc       <= '0;
            r_set       <= '0;
            r_e_prev_ld <= '0;
            r_acc_ld    <= '0;
            r_e_new     <= '0;
            r_acc_new   <= '0;
            r_pid_new   <= '0;
            r_duty_new  <= '0;
            r_pid_val   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc_mem[i]     <= '0;
                r_eprev_mem[i]   <= '0;
                r_duty_shadow[i] <= '0;
            end
        end else if (clk_en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= ST_LOAD;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_adc       <= adc_i[int'(r_ch)*ADC_BW +: ADC_BW];
                    r_set       <= set_i[int'(r_ch)*ADC_BW +: ADC_BW];
                    r_man       <= manual_i[r_ch];
                    r_man_duty  <= manual_duty_i[int'(r_ch)*c_ew +: c_ew];
                    r_e_prev_ld <= r_eprev_mem[r_ch];
                    r_acc_ld    <= r_acc_mem[r_ch];
                    r_state     <= ST_MAC;
                end
                ST_MAC: begin
                    r_e_new    <= w_e;
                    r_acc_new  <= w_acc_nxt;
                    r_pid_new  <= w_pid_nxt;
                    r_duty_new <= w_duty_nxt;
                    r_state    <= ST_STORE;
                end
                ST_STORE: begin
                    r_acc_mem[r_ch]                    <= r_acc_new;
                    r_eprev_mem[r_ch]                  <= r_e_new;
                    r_duty_shadow[r_ch]                <= r_duty_new;
                    r_pid_val[int'(r_ch)*c_ew +: c_ew] <= r_pid_new;
                    if (r_ch == c_ch_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_pwm_wrap = (r_cnt == c_cnt_last);
    assign w_cnt_nxt  = w_pwm_wrap ? '0 : r_cnt + 1'b1;

    // Per-channel comparators evaluated on next-cycle counter/duty so pwm_o is a flop
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
        assign w_duty_sel[g] = w_pwm_wrap ? r_duty_shadow[g] : r_duty_active[g];
        assign w_pwm_nxt[g]  = (w_cnt_nxt < w_duty_sel[g]);
    end

    // Shared PWM counter; active duties follow shadows only at the wrap
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_pwm <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_active[i] <= '0;
            end
        end else if (clk_en_i) begin
            r_cnt <= w_cnt_nxt;
            r_pwm <= w_pwm_nxt;
            if (w_pwm_wrap) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty_active[i] <= r_duty_shadow[i];
                end
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign pid_val_o = r_pid_val;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule
`default_nettype wire
